// File: rtl/bht_gshare.sv
// Two-level gshare/bimodal branch predictor with init sweep,
// speculative GHR, mispredict repair and perf counters.
module bht_gshare #(
    parameter int INDEX_BITS = 10,
    parameter int GHR_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter bit GSHARE     = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_ready,
    output logic                prediction,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic                upd_is_jump,
    input  logic                upd_mispredict,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispredicts
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] WNT =
        {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [31:0]           br_q, br_d;
    logic [31:0]           mp_q, mp_d;
    logic [CTR_BITS-1:0]   table_q [ENTRIES];

    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0]   upd_ctr;
    logic [CTR_BITS-1:0]   upd_next;
    logic                  raw_pred;
    logic                  run;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [CTR_BITS-1:0]   wr_data;
    logic                  unused_pc_bits;

    // Table index: word line, optionally folded with the history.
    function automatic logic [INDEX_BITS-1:0] idx_f(
        input logic [INDEX_BITS-1:0] line,
        input logic [GHR_BITS-1:0]   g
    );
        logic [INDEX_BITS-1:0] gx;
        gx = '0;
        gx[GHR_BITS-1:0] = g;
        if (GSHARE) begin
            return line ^ gx;
        end
        return line;
    endfunction

    // Shift a new outcome into a history value; works for GHR_BITS=1.
    function automatic logic [GHR_BITS-1:0] shl_f(
        input logic [GHR_BITS-1:0] g,
        input logic                b
    );
        return GHR_BITS'({g, b});
    endfunction

    assign unused_pc_bits = ^{pred_pc[1:0], pred_pc[31:INDEX_BITS+2],
                              upd_pc[1:0], upd_pc[31:INDEX_BITS+2]};

    assign pred_idx = idx_f(pred_pc[INDEX_BITS+1:2], ghr_q);
    assign upd_idx  = idx_f(upd_pc[INDEX_BITS+1:2], upd_ghr);
    assign raw_pred = table_q[pred_idx][CTR_BITS-1];
    assign upd_ctr  = table_q[upd_idx];

    // Saturating counter training value for the resolved branch.
    always_comb begin
        upd_next = upd_ctr;
        if (upd_is_jump) begin
            upd_next = CTR_MAX;
        end else if (upd_taken) begin
            if (upd_ctr != CTR_MAX) upd_next = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0) upd_next = upd_ctr - 1'b1;
        end
    end

    // FSM state register: reset restarts the sweep at entry 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // FSM next state: sweep every entry once, then run forever.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        unique case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) state_d = S_RUN;
            end
            S_RUN: begin
                state_d = S_RUN;
            end
        endcase
    end

    // FSM outputs: table write port and the prediction gating.
    always_comb begin
        run     = (state_q == S_RUN);
        wr_en   = 1'b0;
        wr_idx  = init_idx_q;
        wr_data = WNT;
        unique case (state_q)
            S_INIT: begin
                wr_en = 1'b1;
            end
            S_RUN: begin
                wr_en   = upd_valid;
                wr_idx  = upd_idx;
                wr_data = upd_next;
            end
        endcase
    end

    assign pred_ready       = run;
    assign prediction       = run & raw_pred;
    assign pred_ghr         = ghr_q;
    assign perf_branches    = br_q;
    assign perf_mispredicts = mp_q;

    // History and perf next state; repair overrides speculation.
    always_comb begin
        ghr_d = ghr_q;
        br_d  = br_q;
        mp_d  = mp_q;
        if (run) begin
            if (upd_valid && upd_mispredict) begin
                ghr_d = shl_f(upd_ghr, upd_taken | upd_is_jump);
            end else if (pred_valid) begin
                ghr_d = shl_f(ghr_q, raw_pred);
            end
            if (upd_valid) begin
                br_d = br_q + 32'd1;
                if (upd_mispredict) mp_d = mp_q + 32'd1;
            end
        end
    end

    // History and perf registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr_q <= '0;
            br_q  <= '0;
            mp_q  <= '0;
        end else begin
            ghr_q <= ghr_d;
            br_q  <= br_d;
            mp_q  <= mp_d;
        end
    end

    // Counter table write; reads above see the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            table_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_bht_gshare.sv
// Bench for bht_gshare: one gshare and one bimodal instance on
// shared stimulus, checked against an integer reference model.
module tb_bht_gshare;

    localparam int N = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_is_jump;
    logic        upd_mispredict;

    logic        rdy_g, prd_g, rdy_b, prd_b;
    logic [7:0]  ghr_g, ghr_b;
    logic [31:0] br_g, mp_g, br_b, mp_b;

    int checks = 0;
    int errors = 0;

    bht_gshare #(.GSHARE(1'b1)) u_gs (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_ready(rdy_g), .prediction(prd_g), .pred_ghr(ghr_g),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_is_jump(upd_is_jump),
        .upd_mispredict(upd_mispredict),
        .perf_branches(br_g), .perf_mispredicts(mp_g)
    );

    bht_gshare #(.GSHARE(1'b0)) u_bm (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_ready(rdy_b), .prediction(prd_b), .pred_ghr(ghr_b),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_is_jump(upd_is_jump),
        .upd_mispredict(upd_mispredict),
        .perf_branches(br_b), .perf_mispredicts(mp_b)
    );

    // Reference model; mode 0 = gshare, mode 1 = bimodal.
    int          m_ctr [2][N];
    int          m_ghr [2];
    bit          m_ready;
    int          m_cnt;
    logic [31:0] m_br, m_mp;

    function automatic int m_idx(int mode, logic [31:0] pc, int g);
        int i;
        i = int'((pc / 4) % N);
        if (mode == 0) i = (i ^ g) % N;
        return i;
    endfunction

    function automatic bit m_pred(int mode, logic [31:0] pc);
        if (!m_ready) return 1'b0;
        return m_ctr[mode][m_idx(mode, pc, m_ghr[mode])] >= 2;
    endfunction

    task automatic tick();
        bit p [2];
        int e, c, o;
        if (!rst_n) begin
            m_ready = 0;
            m_cnt = 0;
            m_br = 0;
            m_mp = 0;
            for (int md = 0; md < 2; md++) begin
                m_ghr[md] = 0;
                for (int k = 0; k < N; k++) m_ctr[md][k] = 1;
            end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == N) m_ready = 1;
        end else begin
            for (int md = 0; md < 2; md++) p[md] = m_pred(md, pred_pc);
            if (upd_valid) begin
                for (int md = 0; md < 2; md++) begin
                    e = m_idx(md, upd_pc, int'(upd_ghr));
                    c = m_ctr[md][e];
                    if (upd_is_jump) c = 3;
                    else if (upd_taken) c = (c < 3) ? c + 1 : 3;
                    else c = (c > 0) ? c - 1 : 0;
                    m_ctr[md][e] = c;
                end
                m_br = m_br + 1;
                if (upd_mispredict) m_mp = m_mp + 1;
            end
            o = (upd_taken || upd_is_jump) ? 1 : 0;
            for (int md = 0; md < 2; md++) begin
                if (upd_valid && upd_mispredict)
                    m_ghr[md] = (int'(upd_ghr) * 2 + o) % 256;
                else if (pred_valid)
                    m_ghr[md] = (m_ghr[md] * 2 + int'(p[md])) % 256;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid = 0;
        pred_pc = 0;
        upd_valid = 0;
        upd_pc = 0;
        upd_ghr = 0;
        upd_taken = 0;
        upd_is_jump = 0;
        upd_mispredict = 0;
    endtask

    task automatic test_reset();
        int n;
        logic [83:0] got;
        idle();
        rst_n = 0;
        tick();
        tick();
        got = {rdy_g, prd_g, ghr_g, br_g, mp_g,
               rdy_b, prd_b, ghr_b};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", got);
        end
        checks++;
        if ({br_b, mp_b} !== 64'd0) begin
            errors++;
            $display("FAIL reset_perf_b got=%h want=0", {br_b, mp_b});
        end
        rst_n = 1;
        n = 0;
        while (rdy_g !== 1'b1 && n < 2000) begin
            pred_valid = 1'($urandom);
            pred_pc = $urandom;
            upd_valid = 1'($urandom);
            upd_pc = $urandom;
            upd_ghr = 8'($urandom);
            upd_taken = 1'($urandom);
            upd_mispredict = 1'($urandom);
            tick();
            n++;
        end
        idle();
        checks++;
        if (n != N || rdy_b !== 1'b1) begin
            errors++;
            $display("FAIL init_len got=%0d rdy_b=%b want=%0d", n, rdy_b, N);
        end
        checks++;
        if ({ghr_g, ghr_b, br_g, mp_g, br_b, mp_b} !== '0) begin
            errors++;
            $display("FAIL init_ignored ghr=%h/%h br=%0d mp=%0d want 0",
                     ghr_g, ghr_b, br_g, mp_g);
        end
        for (int i = 0; i < 16; i++) begin
            pred_pc = $urandom;
            #1;
            checks++;
            if ({prd_g, prd_b} !== 2'b00) begin
                errors++;
                $display("FAIL init_wnt pc=%h got=%b%b want=00",
                         pred_pc, prd_g, prd_b);
            end
        end
    endtask

    task automatic test_bimodal();
        idle();
        upd_valid = 1;
        upd_pc = 32'h100;
        upd_taken = 1;
        tick();
        tick();
        upd_valid = 0;
        pred_pc = 32'h100;
        #1;
        checks++;
        if ({prd_b, prd_g} !== 2'b11) begin
            errors++;
            $display("FAIL bim_taken got=%b%b want=11", prd_b, prd_g);
        end
        upd_valid = 1;
        upd_taken = 0;
        repeat (3) tick();
        #1;
        checks++;
        if (prd_b !== 1'b0) begin
            errors++;
            $display("FAIL bim_nt got=%b want=0", prd_b);
        end
        tick();
        upd_taken = 1;
        tick();
        #1;
        checks++;
        if (prd_b !== 1'b0) begin
            errors++;
            $display("FAIL bim_sat0 got=%b want=0", prd_b);
        end
        tick();
        upd_valid = 0;
        #1;
        checks++;
        if (prd_b !== 1'b1) begin
            errors++;
            $display("FAIL bim_recover got=%b want=1", prd_b);
        end
    endtask

    task automatic test_jump();
        idle();
        upd_valid = 1;
        upd_pc = 32'h40;
        upd_is_jump = 1;
        tick();
        upd_valid = 0;
        pred_pc = 32'h40;
        #1;
        checks++;
        if ({prd_g, prd_b} !== 2'b11) begin
            errors++;
            $display("FAIL jump_sat got=%b%b want=11", prd_g, prd_b);
        end
        upd_valid = 1;
        upd_is_jump = 0;
        tick();
        #1;
        checks++;
        if ({prd_g, prd_b} !== 2'b11) begin
            errors++;
            $display("FAIL jump_nt1 got=%b%b want=11", prd_g, prd_b);
        end
        tick();
        upd_valid = 0;
        #1;
        checks++;
        if ({prd_g, prd_b} !== 2'b00) begin
            errors++;
            $display("FAIL jump_nt2 got=%b%b want=00", prd_g, prd_b);
        end
    endtask

    task automatic test_gshare();
        idle();
        upd_valid = 1;
        upd_mispredict = 1;
        upd_ghr = 8'h02;
        upd_taken = 1;
        upd_pc = 32'h300;
        tick();
        checks++;
        if ({ghr_g, ghr_b} !== 16'h0505) begin
            errors++;
            $display("FAIL gs_ghr5 got=%h/%h want=05", ghr_g, ghr_b);
        end
        upd_mispredict = 0;
        upd_taken = 0;
        upd_is_jump = 1;
        upd_pc = 32'h0;
        upd_ghr = 8'h05;
        tick();
        idle();
        #1;
        checks++;
        if ({prd_g, prd_b} !== 2'b11) begin
            errors++;
            $display("FAIL gs_idx5 got=%b%b want=11", prd_g, prd_b);
        end
        pred_valid = 1;
        tick();
        pred_valid = 0;
        #1;
        checks++;
        if ({ghr_g, ghr_b} !== 16'h0B0B) begin
            errors++;
            $display("FAIL gs_shift got=%h/%h want=0B", ghr_g, ghr_b);
        end
        checks++;
        if ({prd_g, prd_b} !== 2'b01) begin
            errors++;
            $display("FAIL gs_xor got=%b%b want=01", prd_g, prd_b);
        end
    endtask

    task automatic test_repair();
        logic [31:0] mg, mb;
        idle();
        mg = mp_g;
        mb = mp_b;
        pred_valid = 1;
        upd_valid = 1;
        upd_mispredict = 1;
        upd_ghr = 8'h80;
        upd_pc = 32'h200;
        tick();
        idle();
        checks++;
        if ({ghr_g, ghr_b} !== 16'h0000) begin
            errors++;
            $display("FAIL repair_ghr got=%h/%h want=00", ghr_g, ghr_b);
        end
        checks++;
        if (mp_g !== mg + 1 || mp_b !== mb + 1) begin
            errors++;
            $display("FAIL repair_perf got=%0d/%0d want=%0d/%0d",
                     mp_g, mp_b, mg + 1, mb + 1);
        end
    endtask

    task automatic test_random();
        logic [19:0]  got_s, exp_s;
        logic [127:0] got_p, exp_p;
        for (int i = 0; i < 600; i++) begin
            pred_valid = 1'($urandom);
            pred_pc = $urandom;
            pred_pc[11:2] = 10'($urandom_range(0, 15));
            upd_valid = ($urandom_range(0, 9) < 6);
            upd_pc = $urandom;
            upd_pc[11:2] = 10'($urandom_range(0, 15));
            upd_ghr = 8'($urandom_range(0, 7));
            upd_taken = 1'($urandom);
            upd_is_jump = ($urandom_range(0, 9) == 0);
            upd_mispredict = ($urandom_range(0, 3) == 0);
            #1;
            got_s = {rdy_g, prd_g, ghr_g, rdy_b, prd_b, ghr_b};
            exp_s = {m_ready, m_pred(0, pred_pc), 8'(m_ghr[0]),
                     m_ready, m_pred(1, pred_pc), 8'(m_ghr[1])};
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL rnd_pred cyc=%0d got=%h want=%h",
                         i, got_s, exp_s);
            end
            got_p = {br_g, mp_g, br_b, mp_b};
            exp_p = {m_br, m_mp, m_br, m_mp};
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("FAIL rnd_perf cyc=%0d got=%h want=%h",
                         i, got_p, exp_p);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid_run();
        int n;
        logic [31:0] pcs [4];
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++;
        if ({br_g, mp_g, br_b, mp_b, rdy_g, rdy_b} !== '0) begin
            errors++;
            $display("FAIL rerst_state br=%0d mp=%0d rdy=%b%b want 0",
                     br_g, mp_g, rdy_g, rdy_b);
        end
        n = 0;
        while (rdy_g !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n != N) begin
            errors++;
            $display("FAIL rerst_len got=%0d want=%0d", n, N);
        end
        pcs[0] = 32'h100;
        pcs[1] = 32'h40;
        pcs[2] = 32'h0;
        pcs[3] = 32'h14;
        for (int i = 0; i < 4; i++) begin
            pred_pc = pcs[i];
            #1;
            checks++;
            if ({prd_g, prd_b} !== 2'b00) begin
                errors++;
                $display("FAIL rerst_pred pc=%h got=%b%b want=00",
                         pred_pc, prd_g, prd_b);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bimodal();
        test_jump();
        test_gshare();
        test_repair();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
